// File: rtl/math_pipelined_sequencer.sv
// Operand issue / result capture wrapper for math_pipelined: holds operands for the
// ALU settle time, then captures the full result bundle behind a valid/ready handshake.
module math_pipelined_sequencer #(
    parameter int WIDTH       = 8,
    parameter int LATENCY     = 4,
    parameter int HOLD_CYCLES = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    output logic [WIDTH-1:0] alu_i1,
    output logic [WIDTH-1:0] alu_i2,
    output logic [WIDTH-1:0] alu_i3,
    input  logic [WIDTH-1:0] alu_sum,
    input  logic [WIDTH-1:0] alu_sub,
    input  logic             alu_and,
    input  logic             alu_or,
    input  logic             alu_xor,
    input  logic             alu_eq,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [WIDTH-1:0] out_sub,
    output logic             out_and,
    output logic             out_or,
    output logic             out_xor,
    output logic             out_eq,
    output logic             out_neq,
    output logic             busy
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);

    // The ALU outputs are only trustworthy one cycle after its last pipeline stage settles.
    generate
        if (HOLD_CYCLES < LATENCY + 1 || HOLD_CYCLES < 1) begin : g_bad_hold
            $error("math_pipelined_sequencer: HOLD_CYCLES must be >= LATENCY+1 and >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_DONE} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] sub;
        logic             f_and;
        logic             f_or;
        logic             f_xor;
        logic             f_eq;
        logic             f_neq;
    } result_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    result_t         res;
    logic            accept;
    logic            capture;

    assign in_ready = (state == S_IDLE) || (state == S_DONE && out_ready);
    assign accept   = in_valid && in_ready;
    assign capture  = (state == S_HOLD) && (cnt == '0);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_HOLD;
            S_HOLD:  if (capture) state_nxt = S_DONE;
            S_DONE:  if (out_ready) state_nxt = accept ? S_HOLD : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            alu_i1 <= '0;
            alu_i2 <= '0;
            alu_i3 <= '0;
            res    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt    <= CW'(HOLD_CYCLES - 1);
                alu_i1 <= in_a;
                alu_i2 <= in_b;
                alu_i3 <= in_c;
            end else if (state == S_HOLD && cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
            // neq is derived from eq so both flags come from the same settled compare
            if (capture) begin
                res <= '{sum: alu_sum, sub: alu_sub, f_and: alu_and, f_or: alu_or,
                         f_xor: alu_xor, f_eq: alu_eq, f_neq: ~alu_eq};
            end
        end
    end

    assign busy      = (state == S_HOLD);
    assign out_valid = (state == S_DONE);
    assign out_sum   = res.sum;
    assign out_sub   = res.sub;
    assign out_and   = res.f_and;
    assign out_or    = res.f_or;
    assign out_xor   = res.f_xor;
    assign out_eq    = res.f_eq;
    assign out_neq   = res.f_neq;

endmodule
